// File: rtl/pc_sequencer.sv
// pc_sequencer: 6502 fetch sequencer.
// It fetches the reset vector, then each opcode and its operand bytes.
// It steers the program counter through ps/pc_in, resolves JMP abs itself,
// and presents complete instructions to the execute stage.

package pc_sequencer_pkg;
  typedef logic [15:0] addr_t;
  typedef enum logic [1:0] {
    PS_HOLD = 2'd0,
    PS_INC  = 2'd1,
    PS_ABS  = 2'd2
  } ps_t;
endpackage

module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter addr_t      RESET_VEC  = 16'hFFFC,
  parameter logic [7:0] JMP_ABS_OP = 8'h4C
) (
  input  logic        clk,
  input  logic        rst,
  input  addr_t       pc,
  input  logic [7:0]  din,
  input  logic        mem_wait,
  input  logic [1:0]  op_len,
  input  logic        exec_done,
  input  logic        br_take,
  input  addr_t       br_target,
  output ps_t         ps,
  output addr_t       pc_in,
  output logic [15:0] addr,
  output logic [7:0]  opcode,
  output logic [15:0] operand,
  output logic        instr_valid
);

  typedef enum logic [2:0] {
    S_VEC_LO = 3'd0,
    S_VEC_HI = 3'd1,
    S_FETCH  = 3'd2,
    S_DECODE = 3'd3,
    S_OPER1  = 3'd4,
    S_OPER2  = 3'd5,
    S_EXEC   = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_opcode;
  logic [7:0]  w_opcode_nxt;
  logic [15:0] r_operand;
  logic [15:0] w_operand_nxt;
  logic [7:0]  r_vec_lo;
  logic [7:0]  w_vec_lo_nxt;
  logic [1:0]  w_len;
  ps_t         w_ps;
  addr_t       w_pc_in;
  logic [15:0] w_addr;
  logic        w_instr_valid;

  // An illegal operand count of 3 is treated as no operand bytes.
  assign w_len = (op_len == 2'd3) ? 2'd0 : op_len;

  // State, opcode/operand/vector registers; reset discards any partial fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_VEC_LO;
      r_opcode  <= 8'h00;
      r_operand <= 16'h0000;
      r_vec_lo  <= 8'h00;
    end else begin
      r_state   <= w_state_nxt;
      r_opcode  <= w_opcode_nxt;
      r_operand <= w_operand_nxt;
      r_vec_lo  <= w_vec_lo_nxt;
    end
  end

  // Next state, register loads and combinational PC/memory controls.
  always_comb begin
    w_state_nxt   = r_state;
    w_opcode_nxt  = r_opcode;
    w_operand_nxt = r_operand;
    w_vec_lo_nxt  = r_vec_lo;
    w_ps          = PS_HOLD;
    w_pc_in       = 16'h0000;
    w_addr        = pc;
    w_instr_valid = 1'b0;

    case (r_state)
      S_VEC_LO: begin
        w_addr = RESET_VEC;
        if (!mem_wait) begin
          w_vec_lo_nxt = din;
          w_state_nxt  = S_VEC_HI;
        end
      end
      S_VEC_HI: begin
        w_addr = RESET_VEC + 16'd1;
        if (!mem_wait) begin
          w_ps        = PS_ABS;
          w_pc_in     = {din, r_vec_lo};
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        if (!mem_wait) begin
          w_ps          = PS_INC;
          w_opcode_nxt  = din;
          w_operand_nxt = 16'h0000;
          w_state_nxt   = S_DECODE;
        end
      end
      S_DECODE: begin
        w_state_nxt = (w_len == 2'd0) ? S_EXEC : S_OPER1;
      end
      S_OPER1: begin
        if (!mem_wait) begin
          w_ps               = PS_INC;
          w_operand_nxt[7:0] = din;
          w_state_nxt        = (w_len == 2'd2) ? S_OPER2 : S_EXEC;
        end
      end
      S_OPER2: begin
        if (!mem_wait) begin
          w_operand_nxt[15:8] = din;
          if (r_opcode == JMP_ABS_OP) begin
            w_ps        = PS_ABS;
            w_pc_in     = {din, r_operand[7:0]};
            w_state_nxt = S_FETCH;
          end else begin
            w_ps        = PS_INC;
            w_state_nxt = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        w_instr_valid = 1'b1;
        if (exec_done) begin
          w_state_nxt = S_FETCH;
          if (br_take) begin
            w_ps    = PS_ABS;
            w_pc_in = br_target;
          end
        end
      end
      default: begin
        w_state_nxt = S_VEC_LO;
      end
    endcase

    // Reset wins: the PC must not step or load on the reset edge.
    if (rst) begin
      w_ps    = PS_HOLD;
      w_pc_in = 16'h0000;
    end
  end

  assign ps          = w_ps;
  assign pc_in       = w_pc_in;
  assign addr        = w_addr;
  assign instr_valid = w_instr_valid;
  assign opcode      = r_opcode;
  assign operand     = r_operand;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: memory, decoder and program counter around the DUT,
// an instruction-level reference model checked every cycle, plus directed
// literal checks along a fixed program.

module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  addr_t       pc = 16'h0000;
  logic [7:0]  din;
  logic        mem_wait;
  logic [1:0]  op_len;
  logic        exec_done;
  logic        br_take;
  addr_t       br_target;
  ps_t         ps;
  addr_t       pc_in;
  logic [15:0] addr;
  logic [7:0]  opcode;
  logic [15:0] operand;
  logic        instr_valid;

  logic [7:0]  mem [0:65535];

  int n_chk  = 0;
  int n_fail = 0;

  pc_sequencer #(.RESET_VEC(16'hFFFC), .JMP_ABS_OP(8'h4C)) dut (
    .clk(clk), .rst(rst), .pc(pc), .din(din), .mem_wait(mem_wait),
    .op_len(op_len), .exec_done(exec_done), .br_take(br_take),
    .br_target(br_target), .ps(ps), .pc_in(pc_in), .addr(addr),
    .opcode(opcode), .operand(operand), .instr_valid(instr_valid)
  );

  always #5 clk = ~clk;

  // Memory read data is valid in the cycle the address is presented.
  assign din = mem[addr];

  // Decoder: operand byte count per opcode (FF exercises the illegal 3).
  always_comb begin
    case (opcode)
      8'h4C:   op_len = 2'd2;
      8'hAD:   op_len = 2'd2;
      8'hA9:   op_len = 2'd1;
      8'hFF:   op_len = 2'd3;
      default: op_len = 2'd0;
    endcase
  end

  // Program counter driven by the sequencer's step control.
  always @(posedge clk) begin
    case (ps)
      PS_INC:  pc <= pc + 16'd1;
      PS_ABS:  pc <= pc_in;
      default: pc <= pc;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: vector bytes fetched, bytes of the current instruction
  // fetched, whether its length is known, and the captured bytes.
  int         m_boot;
  int         m_nb;
  int         m_len;
  bit         m_dec;
  bit         m_live = 1'b0;
  logic [7:0] m_op;
  logic [7:0] m_veclo;
  logic [15:0] m_oper;

  always @(posedge clk) begin
    if (rst) begin
      m_live = 1'b1; m_boot = 0; m_nb = 0; m_len = 0; m_dec = 1'b0;
      m_op = 8'h00; m_oper = 16'h0000; m_veclo = 8'h00;
    end else if (m_live) begin
      if (m_boot == 0) begin
        if (!mem_wait) begin m_veclo = din; m_boot = 1; end
      end else if (m_boot == 1) begin
        if (!mem_wait) begin m_boot = 2; m_nb = 0; end
      end else if (m_nb == 0) begin
        if (!mem_wait) begin m_op = din; m_oper = 16'h0000; m_nb = 1; m_dec = 1'b0; end
      end else if (!m_dec) begin
        m_dec = 1'b1;
        m_len = (op_len == 2'd3) ? 0 : int'(op_len);
      end else if (m_nb < 1 + m_len) begin
        if (!mem_wait) begin
          if (m_nb == 1) m_oper[7:0] = din;
          else           m_oper[15:8] = din;
          if (m_nb == 2 && m_op == 8'h4C) m_nb = 0;
          else                            m_nb = m_nb + 1;
        end
      end else if (exec_done) begin
        m_nb = 0;
      end
    end
  end

  // Compare DUT outputs with the model on every cycle after the first reset.
  always @(negedge clk) begin
    ps_t         e_ps;
    addr_t       e_pcin;
    logic [15:0] e_addr;
    logic        e_valid;
    if (m_live) begin
      e_ps = PS_HOLD; e_pcin = 16'h0000; e_addr = pc; e_valid = 1'b0;
      if (m_boot == 0) begin
        e_addr = 16'hFFFC;
      end else if (m_boot == 1) begin
        e_addr = 16'hFFFD;
        if (!mem_wait) begin e_ps = PS_ABS; e_pcin = {din, m_veclo}; end
      end else if (m_nb == 0) begin
        if (!mem_wait) e_ps = PS_INC;
      end else if (!m_dec) begin
        e_ps = PS_HOLD;
      end else if (m_nb < 1 + m_len) begin
        if (!mem_wait) begin
          if (m_nb == 2 && m_op == 8'h4C) begin e_ps = PS_ABS; e_pcin = {din, m_oper[7:0]}; end
          else e_ps = PS_INC;
        end
      end else begin
        e_valid = 1'b1;
        if (exec_done && br_take) begin e_ps = PS_ABS; e_pcin = br_target; end
      end
      if (rst) begin e_ps = PS_HOLD; e_pcin = 16'h0000; end
      chk("model_ps", 32'(ps), 32'(e_ps));
      chk("model_pc_in", 32'(pc_in), 32'(e_pcin));
      chk("model_addr", 32'(addr), 32'(e_addr));
      chk("model_valid", 32'(instr_valid), 32'(e_valid));
      chk("model_opcode", 32'(opcode), 32'(m_op));
      chk("model_operand", 32'(operand), 32'(m_oper));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; mem_wait = 1'b0; exec_done = 1'b0; br_take = 1'b0; br_target = 16'h0000;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'hFFFC] = 8'h34; mem[16'hFFFD] = 8'h12;
    mem[16'h1234] = 8'hEA;
    mem[16'h1235] = 8'h4C; mem[16'h1236] = 8'h00; mem[16'h1237] = 8'h80;
    mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h55; mem[16'h8002] = 8'hEA;
    mem[16'hC000] = 8'hFF;
    mem[16'hC001] = 8'hAD; mem[16'hC002] = 8'h78; mem[16'hC003] = 8'h56;
    mem[16'hC004] = 8'h4C; mem[16'hC005] = 8'h00; mem[16'hC006] = 8'h90;

    step(); step();
    rst = 1'b0; #1;                                    // cycle 0: VEC_LO
    chk("rst_addr", 32'(addr), 32'h0000FFFC);
    chk("rst_ps", 32'(ps), 32'(PS_HOLD));
    chk("rst_pc_in", 32'(pc_in), 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_opcode", 32'(opcode), 32'h0);
    chk("rst_operand", 32'(operand), 32'h0);
    step();                                            // cycle 1: VEC_HI
    chk("vec_hi_addr", 32'(addr), 32'h0000FFFD);
    chk("vec_hi_ps", 32'(ps), 32'(PS_ABS));
    chk("vec_hi_pc_in", 32'(pc_in), 32'h00001234);
    step(); exec_done = 1'b1; #1;                      // cycle 2: FETCH EA
    chk("vec_pc", 32'(pc), 32'h00001234);
    chk("vec_fetch_addr", 32'(addr), 32'h00001234);
    step(); step();                                    // cycle 4: EXEC EA
    chk("nop_valid", 32'(instr_valid), 32'h1);
    chk("nop_opcode", 32'(opcode), 32'h000000EA);
    chk("nop_operand", 32'(operand), 32'h0);
    step();                                            // cycle 5: FETCH 4C
    chk("nop_valid_once", 32'(instr_valid), 32'h0);
    chk("nop_next_addr", 32'(addr), 32'h00001235);
    step(); step(); step();                            // cycle 8: OPER2
    chk("jmp_ps", 32'(ps), 32'(PS_ABS));
    chk("jmp_pc_in", 32'(pc_in), 32'h00008000);
    chk("jmp_no_valid", 32'(instr_valid), 32'h0);
    step();                                            // cycle 9: FETCH A9
    chk("jmp_pc", 32'(pc), 32'h00008000);
    chk("jmp_fetch_addr", 32'(addr), 32'h00008000);
    step(); step(); mem_wait = 1'b1; #1;               // cycle 11: OPER1 wait
    chk("wait1_ps", 32'(ps), 32'(PS_HOLD));
    chk("wait1_addr", 32'(addr), 32'h00008001);
    step();
    chk("wait2_ps", 32'(ps), 32'(PS_HOLD));
    chk("wait2_addr", 32'(addr), 32'h00008001);
    step(); mem_wait = 1'b0; #1;                       // cycle 13: OPER1 proceeds
    chk("wait_done_ps", 32'(ps), 32'(PS_INC));
    step();                                            // cycle 14: EXEC A9
    chk("imm_operand", 32'(operand), 32'h00000055);
    chk("imm_opcode", 32'(opcode), 32'h000000A9);
    chk("imm_pc", 32'(pc), 32'h00008002);
    step(); exec_done = 1'b0; #1;                      // cycle 15: FETCH EA
    step();
    for (int i = 0; i < 3; i++) begin                  // cycles 17..19: stalled EXEC
      step();
      chk("stall_valid", 32'(instr_valid), 32'h1);
      chk("stall_ps", 32'(ps), 32'(PS_HOLD));
    end
    step(); exec_done = 1'b1; br_take = 1'b1; br_target = 16'hC000; #1;
    chk("br_valid", 32'(instr_valid), 32'h1);
    chk("br_ps", 32'(ps), 32'(PS_ABS));
    chk("br_pc_in", 32'(pc_in), 32'h0000C000);
    step(); br_take = 1'b0; #1;                        // cycle 21: FETCH FF
    chk("br_fetch_addr", 32'(addr), 32'h0000C000);
    chk("br_valid_end", 32'(instr_valid), 32'h0);
    step(); step();                                    // cycle 23: EXEC FF
    chk("illegal_len_valid", 32'(instr_valid), 32'h1);
    chk("illegal_len_opcode", 32'(opcode), 32'h000000FF);
    step(); step(); step(); step(); step();            // cycle 28: EXEC AD
    chk("abs_operand", 32'(operand), 32'h00005678);
    chk("abs_pc", 32'(pc), 32'h0000C004);
    step(); step(); step(); step(); rst = 1'b1; #1;    // cycle 32: OPER2 of JMP
    chk("rst_mid_ps", 32'(ps), 32'(PS_HOLD));
    step(); rst = 1'b0; mem_wait = 1'b1; #1;           // cycle 33: VEC_LO
    chk("rst_mid_operand", 32'(operand), 32'h0);
    chk("rst_mid_valid", 32'(instr_valid), 32'h0);
    chk("rst_mid_addr", 32'(addr), 32'h0000FFFC);
    chk("rst_mid_pc", 32'(pc), 32'h0000C006);
    step(); mem_wait = 1'b0; #1;
    chk("vec_wait_addr", 32'(addr), 32'h0000FFFC);
    step();
    chk("vec2_hi_addr", 32'(addr), 32'h0000FFFD);
    step();
    chk("vec2_pc", 32'(pc), 32'h00001234);
    step(); step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
